// File: rtl/mux_4to1.sv
// mux_4to1: 4-to-1 single-bit multiplexer with a registered copy of the
// selected bit and a one-hot decode of the select.
//
// Optional feature macro: MUX_4TO1_SEL_CHG_EN
//   Defined   - S is registered every clock and sel_chg pulses for one
//               cycle after the select changes.
//   Undefined - no select register is built and sel_chg is tied low.
// Y, Y_q and sel_oh behave identically in both builds.
module mux_4to1 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic [1:0] S,
  input  logic       en,
  output logic       Y,
  output logic       Y_q,
  output logic [3:0] sel_oh,
  output logic       sel_chg
);

  // Select the data bit and build the one-hot decode.
  // An unknown select falls into the default arm, so Y and sel_oh go to zero.
  always_comb begin
    Y      = 1'b0;
    sel_oh = 4'b0000;
    case (S)
      2'b00: begin
        Y      = D[0];
        sel_oh = 4'b0001;
      end
      2'b01: begin
        Y      = D[1];
        sel_oh = 4'b0010;
      end
      2'b10: begin
        Y      = D[2];
        sel_oh = 4'b0100;
      end
      2'b11: begin
        Y      = D[3];
        sel_oh = 4'b1000;
      end
      default: begin
        Y      = 1'b0;
        sel_oh = 4'b0000;
      end
    endcase
  end

  // Capture the selected bit when enabled; otherwise hold the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q <= RESET_VAL;
    end else if (en) begin
      Y_q <= Y;
    end
  end

`ifdef MUX_4TO1_SEL_CHG_EN
  logic [1:0] s_q;
  logic       primed;

  // Track the previous select and pulse sel_chg when it differs.
  // The primed flag masks the first edge after reset, since s_q only holds
  // the reset value there rather than a real previous select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= 2'b00;
      primed  <= 1'b0;
      sel_chg <= 1'b0;
    end else begin
      s_q     <= S;
      primed  <= 1'b1;
      sel_chg <= primed && (S != s_q);
    end
  end
`else
  assign sel_chg = 1'b0;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: self-checking bench for mux_4to1.
// A behavioural model derives Y, sel_oh, Y_q and sel_chg directly from the
// input history; a negedge process compares every cycle, and directed
// vectors pin hand-computed literal values.
module tb_mux_4to1;

  localparam logic RESET_VAL = 1'b0;

  logic       clk;
  logic       rst;
  logic [3:0] D;
  logic [1:0] S;
  logic       en;
  logic       Y;
  logic       Y_q;
  logic [3:0] sel_oh;
  logic       sel_chg;

  int checkCount = 0;
  int passCount  = 0;

  mux_4to1 #(.RESET_VAL(RESET_VAL)) dut (
    .clk    (clk),
    .rst    (rst),
    .D      (D),
    .S      (S),
    .en     (en),
    .Y      (Y),
    .Y_q    (Y_q),
    .sel_oh (sel_oh),
    .sel_chg(sel_chg)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: Y_q is the D[S] seen at the last enabled edge,
  // sel_chg is whether the select seen at the last two edges differed.
  logic       modelYq   = RESET_VAL;
  logic       modelChg  = 1'b0;
  int         edgeCount = 0;
  logic [1:0] lastS     = 2'b00;
  logic [1:0] prevS     = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelYq   = RESET_VAL;
      modelChg  = 1'b0;
      edgeCount = 0;
    end else begin
      if (en) modelYq = D[S];
      prevS = lastS;
      lastS = S;
      edgeCount = edgeCount + 1;
`ifdef MUX_4TO1_SEL_CHG_EN
      modelChg = (edgeCount >= 2) && (lastS != prevS);
`else
      modelChg = 1'b0;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("model_Y", {3'b0, Y}, {3'b0, D[S]});
    checkOutput("model_sel_oh", sel_oh, 4'b0001 << S);
    checkOutput("model_Y_q", {3'b0, Y_q}, {3'b0, modelYq});
    checkOutput("model_sel_chg", {3'b0, sel_chg}, {3'b0, modelChg});
  end

  // Drive one input vector shortly after a rising edge.
  task automatic applyStimulus(input logic [3:0] d, input logic [1:0] s,
                               input logic e);
    @(posedge clk);
    #2;
    D  = d;
    S  = s;
    en = e;
    #1;
  endtask

  initial begin
    logic [3:0] ohExp [4];
    logic [3:0] dVec  [4];
    logic [3:0] yVec  [4];
    logic [3:0] rd;
    logic [1:0] rs;

    ohExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst = 1'b1;
    D   = 4'b0000;
    S   = 2'b00;
    en  = 1'b0;
    #3;
    checkOutput("reset_Y_q", {3'b0, Y_q}, {3'b0, RESET_VAL});
    checkOutput("reset_sel_chg", {3'b0, sel_chg}, 4'b0000);
    checkOutput("reset_sel_oh", sel_oh, 4'b0001);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Walking-one and alternating data patterns across the select sweep.
    dVec = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
    yVec = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 4; s++) begin
        applyStimulus(dVec[p], 2'(s), 1'b0);
        checkOutput($sformatf("sweep_Y_d%b_s%0d", dVec[p], s), {3'b0, Y},
                    {3'b0, yVec[p][s]});
        checkOutput($sformatf("sweep_oh_s%0d", s), sel_oh, ohExp[s]);
      end
    end

    // All-ones and all-zeros data.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(4'b1111, 2'(s), 1'b0);
      checkOutput("ones_Y", {3'b0, Y}, 4'b0001);
      applyStimulus(4'b0000, 2'(s), 1'b0);
      checkOutput("zeros_Y", {3'b0, Y}, 4'b0000);
    end

    // Random vectors checked against D[S].
    for (int i = 0; i < 5; i++) begin
      rd = 4'($urandom_range(15));
      rs = 2'($urandom_range(3));
      applyStimulus(rd, rs, 1'b0);
      checkOutput("random_Y", {3'b0, Y}, {3'b0, rd[rs]});
    end

    // Capture with enable, then hold with enable low.
    applyStimulus(4'b0100, 2'b10, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("capture_Y_q", {3'b0, Y_q}, 4'b0001);
    applyStimulus(4'b0000, 2'b10, 1'b0);
    checkOutput("hold_Y", {3'b0, Y}, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("hold_Y_q", {3'b0, Y_q}, 4'b0001);

    // Asynchronous reset in mid-cycle while Y_q is high.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_Y_q", {3'b0, Y_q}, {3'b0, RESET_VAL});
    D = 4'b0100;
    #1;
    checkOutput("rst_Y_tracks", {3'b0, Y}, 4'b0001);
    checkOutput("rst_oh_tracks", sel_oh, 4'b0100);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Select-change pulse.
    applyStimulus(4'b0000, 2'b00, 1'b0);
    applyStimulus(4'b0000, 2'b00, 1'b0);
    applyStimulus(4'b0000, 2'b11, 1'b0);
    @(posedge clk);
    #1;
`ifdef MUX_4TO1_SEL_CHG_EN
    checkOutput("sel_chg_pulse", {3'b0, sel_chg}, 4'b0001);
`else
    checkOutput("sel_chg_tied", {3'b0, sel_chg}, 4'b0000);
`endif
    @(posedge clk);
    #1;
    checkOutput("sel_chg_after", {3'b0, sel_chg}, 4'b0000);

    repeat (2) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
